// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared geometry and enums for the burst memory responder
package burst_mem_pkg;
  localparam int BEATS = 4;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;
  localparam int LINE_OFFSET = 5;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;
endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array: line store addressed by line index and beat, async read, sync write
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int IDX_WIDTH = 10
) (
  input  logic                 clk,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [1:0]           beat,
  input  logic                 we,
  input  logic [BEAT_W-1:0]    wdata,
  output logic [BEAT_W-1:0]    rdata
);
  logic [BEAT_W-1:0] mem [(2**IDX_WIDTH)*BEATS];
  always_ff @(posedge clk)
    if (we) mem[{idx, beat}] <= wdata;
  assign rdata = mem[{idx, beat}];
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat burst memory responder with programmable latency
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int IDX_WIDTH = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [BEAT_W-1:0] mem_wdata,
  output logic [BEAT_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              busy,
  output logic              err,
  output logic [31:0]       reads_served,
  output logic [31:0]       writes_served
);
  state_e state;
  op_e op;
  logic [IDX_WIDTH-1:0] idx;
  logic [7:0] cnt;
  logic [1:0] beat;
  logic [BEAT_W-1:0] rd;
  logic req_ok;
  logic unused_addr;
  assign unused_addr = ^{mem_address[31:LINE_OFFSET+IDX_WIDTH], mem_address[LINE_OFFSET-1:0]};
  // only the latched op's request may be high while a burst is outstanding
  assign req_ok = (op == OP_WRITE) ? (mem_write && !mem_read) : (mem_read && !mem_write);
  assign mem_rdata = mem_resp ? rd : '0;
  burst_mem_array #(.IDX_WIDTH(IDX_WIDTH)) u_array (
    .clk(clk),
    .idx(idx),
    .beat(beat),
    .we(state == BURST && op == OP_WRITE),
    .wdata(mem_wdata),
    .rdata(rd)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op <= OP_READ;
      idx <= '0;
      cnt <= '0;
      beat <= '0;
      mem_resp <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      reads_served <= '0;
      writes_served <= '0;
    end else begin
      case (state)
        IDLE:
          if (mem_read && mem_write) err <= 1'b1;
          else if (mem_read || mem_write) begin
            op <= mem_write ? OP_WRITE : OP_READ;
            idx <= mem_address[LINE_OFFSET +: IDX_WIDTH];
            cnt <= 8'(LATENCY);
            busy <= 1'b1;
            state <= WAIT;
          end
        WAIT: begin
          if (!req_ok) err <= 1'b1;
          if (cnt == 8'd0) begin
            beat <= 2'd0;
            mem_resp <= 1'b1;
            state <= BURST;
          end else cnt <= cnt - 8'd1;
        end
        BURST: begin
          if (!req_ok) err <= 1'b1;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            mem_resp <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (op == OP_WRITE) writes_served <= writes_served + 32'd1;
          else reads_served <= reads_served + 32'd1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb_burst_mem_responder: scoreboard bench over three latency configurations
module tb_burst_mem_responder;
  localparam int LAT[3] = '{4, 0, 255};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mrd[3], mwr[3], resp[3], busy[3], err[3];
  logic [31:0] maddr[3], rds[3], wrs[3];
  logic [63:0] mwd[3], rdata[3];
  logic [63:0] model [int];
  logic [63:0] exp_q[$];
  int exp_rd[3], exp_wr[3];
  logic exp_err[3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    burst_mem_responder #(.IDX_WIDTH(10), .LATENCY(LAT[g])) u_dut (
      .clk(clk), .rst(rst), .mem_read(mrd[g]), .mem_write(mwr[g]),
      .mem_address(maddr[g]), .mem_wdata(mwd[g]), .mem_rdata(rdata[g]),
      .mem_resp(resp[g]), .busy(busy[g]), .err(err[g]),
      .reads_served(rds[g]), .writes_served(wrs[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int key(input int d, input logic [31:0] a, input int k);
    return d * 8192 + int'(a[14:5]) * 4 + k;
  endfunction
  task automatic zero_check(input int d);
    chk("rst_resp", 64'(resp[d]), 64'd0);
    chk("rst_rdata", rdata[d], 64'd0);
    chk("rst_busy", 64'(busy[d]), 64'd0);
    chk("rst_err", 64'(err[d]), 64'd0);
    chk("rst_reads", 64'(rds[d]), 64'd0);
    chk("rst_writes", 64'(wrs[d]), 64'd0);
  endtask
  task automatic clear_model_state();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_rd[i] = 0;
      exp_wr[i] = 0;
      exp_err[i] = 1'b0;
    end
  endtask
  task automatic burst(input int d, input bit wr, input logic [31:0] a,
                       input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3,
                       input int drop_at, input int rst_at);
    logic [63:0] w[4];
    int cyc, n;
    w = '{w0, w1, w2, w3};
    for (int k = 0; k < 4; k++)
      if (wr) begin
        if (rst_at < 0 || k < rst_at) model[key(d, a, k)] = w[k];
      end else exp_q.push_back(model[key(d, a, k)]);
    mwr[d] = wr;
    mrd[d] = !wr;
    maddr[d] = a;
    mwd[d] = w[0];
    cyc = 0;
    while (!resp[d] && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_resp_cycle", 64'(cyc), 64'(LAT[d] + 2));
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == rst_at) begin
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) zero_check(i);
        mrd[d] = 1'b0;
        mwr[d] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_model_state();
        return;
      end
      if (resp[d]) n++;
      if (!wr) chk("rdata", rdata[d], exp_q.pop_front());
      mwd[d] = w[k];
      if (k == drop_at) mrd[d] = 1'b0;
      @(posedge clk); #1;
    end
    chk("resp_beats", 64'(n), 64'd4);
    chk("done_resp", 64'(resp[d]), 64'd0);
    chk("done_rdata", rdata[d], 64'd0);
    chk("done_busy", 64'(busy[d]), 64'd1);
    mrd[d] = 1'b0;
    mwr[d] = 1'b0;
    if (wr) exp_wr[d]++;
    else exp_rd[d]++;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy[d]), 64'd0);
    chk("reads_served", 64'(rds[d]), 64'(exp_rd[d]));
    chk("writes_served", 64'(wrs[d]), 64'(exp_wr[d]));
    chk("err", 64'(err[d]), 64'(exp_err[d]));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      mrd[i] = 1'b0;
      mwr[i] = 1'b0;
      maddr[i] = '0;
      mwd[i] = '0;
    end
    clear_model_state();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) zero_check(i);
    rst = 1'b1;
    @(posedge clk); #1;
    burst(0, 1, 32'h0000_0040, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}, -1, -1);
    burst(0, 0, 32'h0000_0040, '0, '0, '0, '0, -1, -1);
    burst(1, 1, 32'h0000_0060, 64'hdead_beef_0000_0001, 64'hdead_beef_0000_0002,
          64'hdead_beef_0000_0003, 64'hdead_beef_0000_0004, -1, -1);
    burst(1, 0, 32'h0000_0060, '0, '0, '0, '0, -1, -1);
    burst(2, 1, 32'h0000_0100, 64'h1234, 64'h5678, 64'h9abc, 64'hdef0, -1, -1);
    burst(2, 0, 32'h0000_0100, '0, '0, '0, '0, -1, -1);
    burst(0, 1, 32'h0000_805f, 64'ha5a5_0000_0000_0000, 64'ha5a5_1111_0000_0000,
          64'ha5a5_2222_0000_0000, 64'ha5a5_3333_0000_0000, -1, -1);
    burst(0, 0, 32'h0000_0040, '0, '0, '0, '0, -1, -1);
    burst(0, 1, 32'h0000_0080, {16{4'ha}}, {16{4'hb}}, {16{4'hc}}, {16{4'hd}}, -1, -1);
    mrd[0] = 1'b1;
    mwr[0] = 1'b1;
    maddr[0] = 32'h0000_0040;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("both_resp", 64'(resp[0]), 64'd0);
      chk("both_busy", 64'(busy[0]), 64'd0);
    end
    mrd[0] = 1'b0;
    mwr[0] = 1'b0;
    exp_err[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("both_err_sticky", 64'(err[0]), 64'(exp_err[0]));
    chk("both_reads", 64'(rds[0]), 64'(exp_rd[0]));
    chk("both_writes", 64'(wrs[0]), 64'(exp_wr[0]));
    exp_err[1] = 1'b1;
    burst(1, 0, 32'h0000_0060, '0, '0, '0, '0, 1, -1);
    burst(0, 1, 32'h0000_0080, {16{4'h5}}, {16{4'h6}}, {16{4'h7}}, {16{4'h8}}, -1, 2);
    burst(0, 0, 32'h0000_0080, '0, '0, '0, '0, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
